oversample_phase_tracker: RTL
=============================

# oversample_phase_tracker

Parametrised data-recovery back end for the ISERDES oversampling receiver. It consumes the per-cycle sample window (PHASES samples per bit, BPC bits per cycle) and builds an edge-position histogram over a vote interval. It then steps the sampling phase toward the eye centre and emits 0…BPC+1 recovered bits per cycle, handling phase wrap by dropping or inserting a bit. It sits between the ISERDES sample-window register and the downstream word aligner.

## Interface
Parameters:
- PHASES, 4: samples per bit; power of two, ≥4.
- BPC, 2: nominal bits per window.
- VOTE_LEN, 16: valid windows per phase decision.
- ACC_W, 8: width of each per-bin edge accumulator.
- MIN_EDGES, 4: minimum total edges per vote for a decision to count.
- LOCK_DECISIONS, 4: consecutive unchanged decisions required for `locked`.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- win_i  in  W=PHASES*BPC  sample window; win_i[W-1] is the oldest sample.
- win_valid_i  in  1  window qualifier.
- dout_o  out  BPC+1  recovered bits, oldest in dout_o[BPC], left-aligned.
- dout_cnt_o  out  $clog2(BPC+2)  number of valid bits in dout_o (BPC-1, BPC or BPC+1).
- dout_valid_o  out  1  output qualifier.
- phase_o  out  $clog2(PHASES)  current sampling phase.
- locked_o  out  1  phase stable.

## Operation
- Sample position j = 0…W-1, oldest first; x_j = win_i[W-1-j]. x_{-1} is the youngest sample of the previous valid window, registered. Its reset value is 0.
- Edge e_j = x_j ^ x_{j-1}, bin b = j mod PHASES. Per-window histogram is per-bin popcount, range 0…BPC.
- Accumulators add the histogram on each valid window and saturate at 2^ACC_W-1.
- After VOTE_LEN valid windows a decision is made and all accumulators clear on the same cycle.
  - E = bin with maximum count; the lowest index wins ties.
  - Candidate C = (E + PHASES/2) mod PHASES.
- If total edges < MIN_EDGES: phase is held, and the lock counter is neither incremented nor cleared.
- Otherwise phase moves one step toward C by the shortest circular path. If the distance is exactly PHASES/2, step +1. If phase == C, no move.
- Lock counter:
  - An unchanged decision increments it, saturating at LOCK_DECISIONS.
  - A move clears it and deasserts locked_o.
  - locked_o = (counter == LOCK_DECISIONS).
- Sampling: bit k = x_{k*PHASES+phase}, k = 0…BPC-1; normal dout_cnt = BPC.
- Forward wrap (phase PHASES-1 → 0): on the first window sampled with the new phase, bit k=0 is dropped, so dout_cnt = BPC-1.
- Backward wrap (phase 0 → PHASES-1): on the first window sampled with the new phase, prev-window sample x_{W-1} (registered) is prepended as the oldest bit, so dout_cnt = BPC+1.
- win_valid_i low: no accumulation, no output, and prev-sample/prev-window registers are held. The vote count advances only on valid windows.

## Timing
- Pipeline:
  - Stage 1 registers the window, edges and histogram.
  - Stage 2 handles accumulation/decision and sampling/output.
  - dout_valid_o follows win_valid_i by 2 cycles.
- A decision triggered by valid window n updates phase_o on cycle n+2. The new phase applies to windows entering stage 2 from that cycle onward.
- Reset values:
  - phase_o = PHASES/2.
  - locked_o, dout_valid_o, dout_o, dout_cnt_o, accumulators, vote and lock counters are all 0.
- rst mid-operation: everything returns to the reset state on the next edge and in-flight pipeline data is discarded. A decision coinciding with rst is discarded.
- dout_o bits below the valid count are 0.

## Structure
- Package oversample_pkg holds:
  - default PHASES/BPC constants;
  - function circ_step(cur, cand) returning the next phase and wrap direction (none/fwd/bwd);
  - typedef phase_t.
- Sub-module edge_histogram: combinational edge detection plus a registered per-bin popcount (stage 1). The top module holds the accumulators, decision FSM (ACCUM → DECIDE → ACCUM) and sampler.

## Test plan
- PHASES=4, BPC=2; win_i = 8'b11110000 every cycle (edges in bin 0) → phase stays 2. dout_o[2:1] = 2'b10 with cnt = 2 every cycle; locked_o rises after 64 valid windows plus 2 cycles.
- Stream shifted one sample, win_i = 8'b01111000 (edges in bin 1) → after the first decision phase_o goes 2 → 3, locked_o stays low, then rises 4 decisions later.
- From phase 3 with edges in bin 2 → phase 3 → 0 (forward wrap). The first output after the change has cnt = 1, and the following outputs have cnt = 2.
- From phase 0 with edges in bin 1 → phase 0 → 3 (backward wrap). The first output has cnt = 3, with dout_o[2] = previous win_i[0].
- win_i = 8'hFF constant → zero edges; phase and lock counter unchanged over 10 votes. Repeat with win_valid_i toggling 50%: the vote fires after exactly 16 valid windows.
- Assert rst for 1 cycle mid-vote → next cycle phase_o = 2, locked_o = 0, dout_valid_o = 0. The first output reappears 2 cycles after the next valid window.

Source files
------------

// File: rtl/oversample_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oversample_pkg : shared types and circular phase-step helper               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package oversample_pkg;

    localparam int DEF_PHASES  = 4;
    localparam int DEF_BPC     = 2;
    localparam int PHASE_W_MAX = 8;

    typedef logic [PHASE_W_MAX-1:0] phase_t;

    typedef enum logic [1:0] {
        WRAP_NONE = 2'd0,
        WRAP_FWD  = 2'd1,
        WRAP_BWD  = 2'd2
    } wrap_e;

    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_DECIDE = 1'b1
    } vote_state_e;

    typedef struct packed {
        phase_t next;
        wrap_e  wrap;
    } step_t;

    // One step toward cand along the shorter arc; a half-circle tie steps forward.
    function automatic step_t circ_step(phase_t cur, phase_t cand, int unsigned phases);
        step_t  r;
        phase_t mask;
        phase_t diff;
        mask   = phase_t'(phases - 1);
        diff   = (cand - cur) & mask;
        r.next = cur;
        r.wrap = WRAP_NONE;
        if (diff != '0) begin
            if (diff <= phase_t'(phases / 2)) begin
                r.next = (cur + phase_t'(1)) & mask;
                if (cur == mask) r.wrap = WRAP_FWD;
            end else begin
                r.next = (cur - phase_t'(1)) & mask;
                if (cur == '0) r.wrap = WRAP_BWD;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oversample_phase_tracker_edge_histogram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edge_histogram : stage 1 - edge detection and registered per-bin popcount  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module edge_histogram
    import oversample_pkg::*;
#(
    parameter  int PHASES = DEF_PHASES,
    parameter  int BPC    = DEF_BPC,
    localparam int W      = PHASES * BPC,
    localparam int CW     = $clog2(BPC + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               win_i,
    input  logic                       win_valid_i,
    output logic [W-1:0]               win_o,
    output logic                       valid_o,
    output logic                       prev_o,
    output logic [PHASES-1:0][CW-1:0]  hist_o
);

    logic                      prev_q;
    logic                      prevwin_q;
    logic                      valid_q;
    logic [W-1:0]              win_q;
    logic [PHASES-1:0][CW-1:0] hist_q;
    logic [PHASES-1:0][CW-1:0] hist_d;
    logic [W-1:0]              edges;

    // edges[j] is the transition into sample j (oldest first)
    generate
        for (genvar j = 0; j < W; j++) begin : g_edge
            if (j == 0) begin : g_first
                assign edges[j] = win_i[W-1] ^ prev_q;
            end else begin : g_rest
                assign edges[j] = win_i[W-1-j] ^ win_i[W-j];
            end
        end
    endgenerate

    always_comb begin
        hist_d = '0;
        for (int b = 0; b < PHASES; b++) begin
            for (int k = 0; k < BPC; k++) begin
                hist_d[b] = hist_d[b] + CW'(edges[k*PHASES+b]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= 1'b0;
            prevwin_q <= 1'b0;
            valid_q   <= 1'b0;
            win_q     <= '0;
            hist_q    <= '0;
        end else begin
            valid_q <= win_valid_i;
            if (win_valid_i) begin
                win_q     <= win_i;
                hist_q    <= hist_d;
                prevwin_q <= prev_q;
                prev_q    <= win_i[0];
            end
        end
    end

    assign win_o   = win_q;
    assign valid_o = valid_q;
    assign prev_o  = prevwin_q;
    assign hist_o  = hist_q;

endmodule
`default_nettype wire

// File: rtl/oversample_phase_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oversample_phase_tracker : edge-vote phase tracking and bit recovery       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module oversample_phase_tracker
    import oversample_pkg::*;
#(
    parameter  int PHASES         = DEF_PHASES,
    parameter  int BPC            = DEF_BPC,
    parameter  int VOTE_LEN       = 16,
    parameter  int ACC_W          = 8,
    parameter  int MIN_EDGES      = 4,
    parameter  int LOCK_DECISIONS = 4,
    localparam int W              = PHASES * BPC,
    localparam int PW             = $clog2(PHASES),
    localparam int CNTW           = $clog2(BPC + 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    win_i,
    input  logic            win_valid_i,
    output logic [BPC:0]    dout_o,
    output logic [CNTW-1:0] dout_cnt_o,
    output logic            dout_valid_o,
    output logic [PW-1:0]   phase_o,
    output logic            locked_o
);

    localparam int CW = $clog2(BPC + 1);
    localparam int SW = ACC_W + 1;
    localparam int TW = ACC_W + PW + 1;
    localparam int VW = $clog2(VOTE_LEN);
    localparam int LW = $clog2(LOCK_DECISIONS + 1);

    logic [W-1:0]              s1_win;
    logic                      s1_valid;
    logic                      s1_prev;
    logic [PHASES-1:0][CW-1:0] s1_hist;

    edge_histogram #(
        .PHASES (PHASES),
        .BPC    (BPC)
    ) u_edge_histogram (
        .clk         (clk),
        .rst         (rst),
        .win_i       (win_i),
        .win_valid_i (win_valid_i),
        .win_o       (s1_win),
        .valid_o     (s1_valid),
        .prev_o      (s1_prev),
        .hist_o      (s1_hist)
    );

    vote_state_e                  state_q, state_d;
    logic [VW-1:0]                vote_q, vote_d;
    logic [PHASES-1:0][ACC_W-1:0] acc_q, acc_d, acc_sat;
    phase_t                       phase_q, phase_d;
    logic [LW-1:0]                lock_q, lock_d;
    wrap_e                        wrap_q, wrap_d;
    logic [BPC:0]                 dout_q, dout_d;
    logic [CNTW-1:0]              cnt_q, cnt_d;
    logic                         dout_valid_q;

    logic [TW-1:0]    total;
    logic [SW-1:0]    sum;
    logic [ACC_W-1:0] best_cnt;
    phase_t           best;
    phase_t           cand;
    step_t            step;

    // The decision sees the accumulators including the closing window's histogram.
    always_comb begin
        total    = '0;
        sum      = '0;
        best     = '0;
        best_cnt = '0;
        acc_sat  = '0;
        for (int b = 0; b < PHASES; b++) begin
            sum        = {1'b0, acc_q[b]} + SW'(s1_hist[b]);
            acc_sat[b] = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            total      = total + TW'(acc_sat[b]);
            if (b == 0 || acc_sat[b] > best_cnt) begin
                best     = phase_t'(b);
                best_cnt = acc_sat[b];
            end
        end
        cand = (best + phase_t'(PHASES / 2)) & phase_t'(PHASES - 1);
        step = circ_step(phase_q, cand, PHASES);
    end

    always_comb begin
        state_d = state_q;
        vote_d  = vote_q;
        acc_d   = acc_q;
        phase_d = phase_q;
        lock_d  = lock_q;
        wrap_d  = wrap_q;
        if (s1_valid) begin
            acc_d  = acc_sat;
            vote_d = vote_q + VW'(1);
            wrap_d = WRAP_NONE;
            case (state_q)
                ST_ACCUM: begin
                    if (vote_q == VW'(VOTE_LEN - 2)) state_d = ST_DECIDE;
                end
                ST_DECIDE: begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    vote_d  = '0;
                    if (total >= TW'(MIN_EDGES)) begin
                        if (cand == phase_q) begin
                            if (lock_q != LW'(LOCK_DECISIONS)) lock_d = lock_q + LW'(1);
                        end else begin
                            phase_d = step.next;
                            wrap_d  = step.wrap;
                            lock_d  = '0;
                        end
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    logic [W-1:0]   aligned;
    logic [BPC-1:0] bits;

    // bits holds the sampled bits oldest-first in its MSB
    always_comb begin
        aligned = s1_win << phase_q;
        bits    = '0;
        for (int k = 0; k < BPC; k++) begin
            bits[BPC-1-k] = aligned[W-1-k*PHASES];
        end
        case (wrap_q)
            WRAP_FWD: begin
                dout_d = {bits, 1'b0} << 1;
                cnt_d  = CNTW'(BPC - 1);
            end
            WRAP_BWD: begin
                dout_d = {s1_prev, bits};
                cnt_d  = CNTW'(BPC + 1);
            end
            default: begin
                dout_d = {bits, 1'b0};
                cnt_d  = CNTW'(BPC);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACCUM;
            vote_q       <= '0;
            acc_q        <= '0;
            phase_q      <= phase_t'(PHASES / 2);
            lock_q       <= '0;
            wrap_q       <= WRAP_NONE;
            dout_q       <= '0;
            cnt_q        <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vote_q       <= vote_d;
            acc_q        <= acc_d;
            phase_q      <= phase_d;
            lock_q       <= lock_d;
            wrap_q       <= wrap_d;
            dout_valid_q <= s1_valid;
            if (s1_valid) begin
                dout_q <= dout_d;
                cnt_q  <= cnt_d;
            end
        end
    end

    assign dout_o       = dout_q;
    assign dout_cnt_o   = cnt_q;
    assign dout_valid_o = dout_valid_q;
    assign phase_o      = phase_q[PW-1:0];
    assign locked_o     = (lock_q == LW'(LOCK_DECISIONS));

endmodule
`default_nettype wire
